// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Brief    : Shared types and array geometry for the systolic tile feeder.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

   localparam int ARRAY_ROWS       = 4;
   localparam int ARRAY_COLS       = 4;
   localparam int RESULTS_PER_TILE = ARRAY_ROWS * ARRAY_COLS;

   // Feeder sequencing: load operands, arm the array, stream beats,
   // wait for completion, drain the accumulators.
   typedef enum logic [2:0] {
      LOAD  = 3'd0,
      ARM   = 3'd1,
      FEED  = 3'd2,
      WAIT  = 3'd3,
      DRAIN = 3'd4
   } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/tile_operand_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tile_operand_buffer
// Brief    : VECTOR_LENGTH-deep register file holding one tile of A columns
//            and B rows. One write port (load side), one read port (feed).
// Revision : 1.0 - initial release
// ============================================================================
module tile_operand_buffer
   import systolic_pkg::*;
#(
   parameter int INPUT_WIDTH   = 8,
   parameter int VECTOR_LENGTH = 4,
   parameter int IDX_WIDTH     = 3
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              wr_en,
   input  logic [IDX_WIDTH-1:0]              wr_idx,
   input  logic [INPUT_WIDTH*ARRAY_ROWS-1:0] wr_a,
   input  logic [INPUT_WIDTH*ARRAY_COLS-1:0] wr_b,
   input  logic [IDX_WIDTH-1:0]              rd_idx,
   output logic [INPUT_WIDTH*ARRAY_ROWS-1:0] rd_a,
   output logic [INPUT_WIDTH*ARRAY_COLS-1:0] rd_b
);

   logic [INPUT_WIDTH*ARRAY_ROWS-1:0] r_a_mem [VECTOR_LENGTH];
   logic [INPUT_WIDTH*ARRAY_COLS-1:0] r_b_mem [VECTOR_LENGTH];

   // Both halves of a beat land in the same entry; reset discards the tile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < VECTOR_LENGTH; i++) begin
            r_a_mem[i] <= '0;
            r_b_mem[i] <= '0;
         end
      end else if (wr_en) begin
         for (int i = 0; i < VECTOR_LENGTH; i++) begin
            if (wr_idx == IDX_WIDTH'(i)) begin
               r_a_mem[i] <= wr_a;
               r_b_mem[i] <= wr_b;
            end
         end
      end
   end

   // Decoded read so an index past the last entry yields zero, not X.
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int i = 0; i < VECTOR_LENGTH; i++) begin
         if (rd_idx == IDX_WIDTH'(i)) begin
            rd_a = r_a_mem[i];
            rd_b = r_b_mem[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/systolic_tile_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_tile_feeder
// Brief    : Buffers one operand tile, arms a 4x4 systolic array, streams the
//            feed beats, waits for completion (with watchdog) and drains the
//            16 accumulators row-major over a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_tile_feeder
   import systolic_pkg::*;
#(
   parameter int INPUT_WIDTH    = 8,
   parameter int ACC_WIDTH      = 16,
   parameter int VECTOR_LENGTH  = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [INPUT_WIDTH*ARRAY_ROWS-1:0]     in_a,
   input  logic [INPUT_WIDTH*ARRAY_COLS-1:0]     in_b,
   input  logic                                  ready_for_feed,
   output logic                                  tile_clear,
   output logic                                  feed_valid,
   output logic [INPUT_WIDTH*ARRAY_ROWS-1:0]     row_data_bus,
   output logic [INPUT_WIDTH*ARRAY_COLS-1:0]     col_data_bus,
   input  logic                                  tile_done,
   input  logic [ACC_WIDTH*RESULTS_PER_TILE-1:0] tile_result_flat,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [ACC_WIDTH-1:0]                  out_data,
   output logic                                  out_last,
   output logic                                  busy,
   output logic                                  err_timeout
);

   localparam int c_CNT_W  = $clog2(VECTOR_LENGTH + 1);
   localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int c_ROW_W  = INPUT_WIDTH * ARRAY_ROWS;
   localparam int c_COL_W  = INPUT_WIDTH * ARRAY_COLS;
   localparam int c_RES_W  = ACC_WIDTH * RESULTS_PER_TILE;

   localparam logic [c_CNT_W-1:0]  c_LAST_BEAT  = c_CNT_W'(VECTOR_LENGTH - 1);
   localparam logic [c_CNT_W-1:0]  c_FEED_BEATS = c_CNT_W'(VECTOR_LENGTH);
   localparam logic [c_WDOG_W-1:0] c_WDOG_LAST  = c_WDOG_W'(TIMEOUT_CYCLES - 1);
   localparam logic [c_WDOG_W-1:0] c_WDOG_MAX   = c_WDOG_W'(TIMEOUT_CYCLES);
   localparam logic [3:0]          c_LAST_IDX   = 4'(RESULTS_PER_TILE - 1);

   feeder_state_e          r_state,       w_state_d;
   logic [c_CNT_W-1:0]     r_beat_cnt,    w_beat_cnt_d;
   logic [c_CNT_W-1:0]     r_feed_cnt,    w_feed_cnt_d;
   logic [c_WDOG_W-1:0]    r_wdog,        w_wdog_d;
   logic [3:0]             r_idx,         w_idx_d;
   logic [c_RES_W-1:0]     r_result,      w_result_d;
   logic                   r_tile_clear,  w_tile_clear_d;
   logic                   r_feed_valid,  w_feed_valid_d;
   logic [c_ROW_W-1:0]     r_row,         w_row_d;
   logic [c_COL_W-1:0]     r_col,         w_col_d;
   logic                   r_out_valid,   w_out_valid_d;
   logic [ACC_WIDTH-1:0]   r_out_data,    w_out_data_d;
   logic                   r_out_last,    w_out_last_d;
   logic                   r_busy,        w_busy_d;
   logic                   r_err,         w_err_d;

   logic                   w_buf_wr_en;
   logic [c_ROW_W-1:0]     w_buf_rd_a;
   logic [c_COL_W-1:0]     w_buf_rd_b;
   logic [3:0]             w_idx_inc;

   tile_operand_buffer #(
      .INPUT_WIDTH   (INPUT_WIDTH),
      .VECTOR_LENGTH (VECTOR_LENGTH),
      .IDX_WIDTH     (c_CNT_W)
   ) u_buffer (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (w_buf_wr_en),
      .wr_idx (r_beat_cnt),
      .wr_a   (in_a),
      .wr_b   (in_b),
      .rd_idx (r_feed_cnt),
      .rd_a   (w_buf_rd_a),
      .rd_b   (w_buf_rd_b)
   );

   assign w_idx_inc    = r_idx + 4'd1;
   assign in_ready     = (r_state == LOAD);
   assign tile_clear   = r_tile_clear;
   assign feed_valid   = r_feed_valid;
   assign row_data_bus = r_row;
   assign col_data_bus = r_col;
   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_last     = r_out_last;
   assign busy         = r_busy;
   assign err_timeout  = r_err;

   // Next-state and next-output decode; every registered output is derived here.
   always_comb begin
      w_state_d      = r_state;
      w_beat_cnt_d   = r_beat_cnt;
      w_feed_cnt_d   = r_feed_cnt;
      w_wdog_d       = r_wdog;
      w_idx_d        = r_idx;
      w_result_d     = r_result;
      w_tile_clear_d = 1'b0;
      w_feed_valid_d = 1'b0;
      w_row_d        = '0;
      w_col_d        = '0;
      w_out_valid_d  = r_out_valid;
      w_out_data_d   = r_out_data;
      w_out_last_d   = r_out_last;
      w_err_d        = r_err;
      w_buf_wr_en    = 1'b0;

      case (r_state)
         LOAD: begin
            if (in_valid) begin
               w_buf_wr_en = 1'b1;
               if (r_beat_cnt == c_LAST_BEAT) begin
                  w_beat_cnt_d = '0;
                  w_state_d    = ARM;
               end else begin
                  w_beat_cnt_d = r_beat_cnt + 1'b1;
               end
            end
         end
         ARM: begin
            if (ready_for_feed) begin
               w_tile_clear_d = 1'b1;
               w_feed_cnt_d   = '0;
               w_state_d      = FEED;
            end
         end
         FEED: begin
            // First FEED cycle is the one where tile_clear is visible, so the
            // beats follow it directly; the array handles its own skew.
            if (r_feed_cnt == c_FEED_BEATS) begin
               w_feed_cnt_d = '0;
               w_wdog_d     = '0;
               w_state_d    = WAIT;
            end else begin
               w_feed_valid_d = 1'b1;
               w_row_d        = w_buf_rd_a;
               w_col_d        = w_buf_rd_b;
               w_feed_cnt_d   = r_feed_cnt + 1'b1;
            end
         end
         WAIT: begin
            if (tile_done) begin
               w_result_d    = tile_result_flat;
               w_idx_d       = '0;
               w_out_valid_d = 1'b1;
               w_out_data_d  = tile_result_flat[ACC_WIDTH-1:0];
               w_out_last_d  = 1'b0;
               w_wdog_d      = '0;
               w_state_d     = DRAIN;
            end else if (r_wdog == c_WDOG_LAST) begin
               // Give up on this tile; the flag stays set until reset.
               w_err_d   = 1'b1;
               w_wdog_d  = '0;
               w_state_d = LOAD;
            end else if (r_wdog != c_WDOG_MAX) begin
               w_wdog_d = r_wdog + 1'b1;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (r_idx == c_LAST_IDX) begin
                  w_out_valid_d = 1'b0;
                  w_out_data_d  = '0;
                  w_out_last_d  = 1'b0;
                  w_idx_d       = '0;
                  w_state_d     = LOAD;
               end else begin
                  w_idx_d      = w_idx_inc;
                  w_out_data_d = r_result[w_idx_inc*ACC_WIDTH +: ACC_WIDTH];
                  w_out_last_d = (w_idx_inc == c_LAST_IDX);
               end
            end
         end
         default: begin
            w_state_d = LOAD;
         end
      endcase

      w_busy_d = (w_state_d != LOAD);
   end

   // State, counters and registered outputs; reset drops any in-flight pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= LOAD;
         r_beat_cnt   <= '0;
         r_feed_cnt   <= '0;
         r_wdog       <= '0;
         r_idx        <= '0;
         r_result     <= '0;
         r_tile_clear <= 1'b0;
         r_feed_valid <= 1'b0;
         r_row        <= '0;
         r_col        <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_last   <= 1'b0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_beat_cnt   <= w_beat_cnt_d;
         r_feed_cnt   <= w_feed_cnt_d;
         r_wdog       <= w_wdog_d;
         r_idx        <= w_idx_d;
         r_result     <= w_result_d;
         r_tile_clear <= w_tile_clear_d;
         r_feed_valid <= w_feed_valid_d;
         r_row        <= w_row_d;
         r_col        <= w_col_d;
         r_out_valid  <= w_out_valid_d;
         r_out_data   <= w_out_data_d;
         r_out_last   <= w_out_last_d;
         r_busy       <= w_busy_d;
         r_err        <= w_err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_tile_feeder
// Brief    : Self-checking bench: behavioural array model, tile-level
//            reference (matrix product) and a per-cycle compare process.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_tile_feeder;

   localparam int VL       = 4;
   localparam int T        = 256;
   localparam int IW       = 8;
   localparam int AW       = 16;
   localparam int DONE_LAT = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [IW*4-1:0] in_a;
   logic [IW*4-1:0] in_b;
   logic            ready_for_feed;
   logic            tile_clear;
   logic            feed_valid;
   logic [IW*4-1:0] row_data_bus;
   logic [IW*4-1:0] col_data_bus;
   logic            tile_done;
   logic [AW*16-1:0] tile_result_flat;
   logic            out_valid;
   logic            out_ready;
   logic [AW-1:0]   out_data;
   logic            out_last;
   logic            busy;
   logic            err_timeout;

   systolic_tile_feeder #(
      .INPUT_WIDTH    (IW),
      .ACC_WIDTH      (AW),
      .VECTOR_LENGTH  (VL),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_a             (in_a),
      .in_b             (in_b),
      .ready_for_feed   (ready_for_feed),
      .tile_clear       (tile_clear),
      .feed_valid       (feed_valid),
      .row_data_bus     (row_data_bus),
      .col_data_bus     (col_data_bus),
      .tile_done        (tile_done),
      .tile_result_flat (tile_result_flat),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_last         (out_last),
      .busy             (busy),
      .err_timeout      (err_timeout)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- tile-level reference ----------------
   int unsigned tile_a [4][VL];   // A[r][k]
   int unsigned tile_b [VL][4];   // B[k][c]

   function automatic logic [AW-1:0] ref_word(input int r, input int c);
      int unsigned s;
      s = 0;
      for (int k = 0; k < VL; k++) s += tile_a[r][k] * tile_b[k][c];
      return s[AW-1:0];
   endfunction

   function automatic logic [IW*4-1:0] exp_row(input int k);
      logic [IW*4-1:0] v;
      for (int r = 0; r < 4; r++) v[r*IW +: IW] = tile_a[r][k][IW-1:0];
      return v;
   endfunction

   function automatic logic [IW*4-1:0] exp_col(input int k);
      logic [IW*4-1:0] v;
      for (int c = 0; c < 4; c++) v[c*IW +: IW] = tile_b[k][c][IW-1:0];
      return v;
   endfunction

   // ---------------- behavioural array model ----------------
   bit done_en   = 1'b1;
   bit stray_req = 1'b0;

   initial begin
      logic [AW-1:0]   acc [16];
      logic            s_tc, s_fv;
      logic [IW*4-1:0] s_row, s_col;
      int              cd, fcnt;
      int unsigned     pa, pb;
      tile_done = 1'b0;
      tile_result_flat = '0;
      cd = 0;
      fcnt = 0;
      for (int i = 0; i < 16; i++) acc[i] = '0;
      forever begin
         @(negedge clk);
         s_tc = tile_clear; s_fv = feed_valid; s_row = row_data_bus; s_col = col_data_bus;
         @(posedge clk);
         #1;
         tile_done = 1'b0;
         if (!rst_n) begin
            cd = 0;
            fcnt = 0;
         end else begin
            if (s_tc) begin
               for (int i = 0; i < 16; i++) acc[i] = '0;
               fcnt = 0;
            end
            if (s_fv) begin
               for (int r = 0; r < 4; r++)
                  for (int c = 0; c < 4; c++) begin
                     pa = s_row[r*IW +: IW];
                     pb = s_col[c*IW +: IW];
                     acc[r*4+c] = acc[r*4+c] + AW'(pa * pb);
                  end
               fcnt++;
               if (fcnt == VL && done_en) cd = DONE_LAT;
            end else if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  tile_done = 1'b1;
                  for (int i = 0; i < 16; i++) tile_result_flat[i*AW +: AW] = acc[i];
               end
            end
         end
         if (stray_req) tile_done = 1'b1;
      end
   end

   // ---------------- out_ready driver ----------------
   bit rand_ready = 1'b0;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- compare process ----------------
   int  load_beats = 0, feed_left = 0, k_feed = 0, w = 0, drain_n = 0;
   int  tiles_done = 0, tc_total = 0, fv_total = 0;
   bit  arm_next = 0, in_arm = 0, tc_next = 0, exp_tc = 0, in_wait = 0;
   bit  go_drain = 0, exp_drain = 0, end_drain = 0, stall_prev = 0, exp_err = 0, exp_busy = 0;
   logic [AW-1:0] held_data;
   logic          held_last;
   logic [AW-1:0] exp_res [16];
   logic [AW-1:0] obs [16];

   always @(negedge clk) begin
      if (!rst_n) begin
         load_beats = 0; arm_next = 0; in_arm = 0; tc_next = 0; exp_tc = 0;
         feed_left = 0; in_wait = 0; w = 0; go_drain = 0; exp_drain = 0;
         end_drain = 0; stall_prev = 0; exp_err = 0;
      end else begin
         if (arm_next) begin in_arm = 1; arm_next = 0; end
         exp_tc = tc_next; tc_next = 0;
         if (go_drain) begin exp_drain = 1; drain_n = 0; go_drain = 0; stall_prev = 0; end
         if (end_drain) begin exp_drain = 0; end_drain = 0; tiles_done++; end
         if (in_wait) begin
            w++;
            if (w == T) begin exp_err = 1; in_wait = 0; end
         end
         // feed beats follow tile_clear back-to-back, zero buses otherwise
         if (feed_left > 0) begin
            chk("feed_valid", feed_valid, 1);
            chk("row_data_bus", row_data_bus, exp_row(k_feed));
            chk("col_data_bus", col_data_bus, exp_col(k_feed));
            k_feed++; feed_left--;
            if (feed_valid) fv_total++;
            if (feed_left == 0) begin in_wait = 1; w = -1; end
         end else begin
            chk("feed_idle", feed_valid, 0);
            chk("row_idle", row_data_bus, 0);
            chk("col_idle", col_data_bus, 0);
         end
         if (in_wait && w >= 0 && tile_done) begin
            in_wait = 0; go_drain = 1;
            for (int i = 0; i < 16; i++) exp_res[i] = ref_word(i / 4, i % 4);
         end
         chk("tile_clear", tile_clear, exp_tc);
         if (tile_clear) tc_total++;
         if (exp_tc) begin feed_left = VL; k_feed = 0; end
         // drain stream
         if (exp_drain) begin
            chk("out_valid", out_valid, 1);
            if (stall_prev) begin
               chk("stall_data", out_data, held_data);
               chk("stall_last", out_last, held_last);
            end
            if (out_ready) begin
               chk("out_data", out_data, exp_res[drain_n]);
               chk("out_last", out_last, (drain_n == 15));
               obs[drain_n] = out_data;
               drain_n++;
               if (drain_n == 16) end_drain = 1;
               stall_prev = 0;
            end else begin
               stall_prev = 1; held_data = out_data; held_last = out_last;
            end
         end else begin
            chk("out_valid_idle", out_valid, 0);
         end
         exp_busy = in_arm || exp_tc || (feed_left > 0) || in_wait || go_drain || exp_drain;
         chk("in_ready", in_ready, !exp_busy);
         chk("busy", busy, exp_busy);
         chk("err_timeout", err_timeout, exp_err);
         if (in_valid && in_ready) begin
            load_beats++;
            if (load_beats == VL) begin load_beats = 0; arm_next = 1; end
         end
         if (in_arm && ready_for_feed) begin in_arm = 0; tc_next = 1; end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: identity A, B=k*4+c+1; mode 1: A=1, B=2; mode 2: random
   task automatic load_tile(input int mode);
      for (int k = 0; k < VL; k++) begin
         logic [IW*4-1:0] a, b;
         int unsigned v;
         bit acc;
         int g;
         for (int r = 0; r < 4; r++) begin
            v = (mode == 0) ? ((r == k) ? 1 : 0) : (mode == 1) ? 1 : $urandom_range(0, 255);
            tile_a[r][k] = v;
            a[r*IW +: IW] = v[IW-1:0];
         end
         for (int c = 0; c < 4; c++) begin
            v = (mode == 0) ? (k * 4 + c + 1) : (mode == 1) ? 2 : $urandom_range(0, 255);
            tile_b[k][c] = v;
            b[c*IW +: IW] = v[IW-1:0];
         end
         if ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; step(); end
         in_valid = 1'b1; in_a = a; in_b = b;
         acc = 0; g = 0;
         while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            step();
            g++;
            if (g > 1000) begin
               $display("FAIL load_stuck actual=0 expected=1");
               $fatal(1);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_tile(input string name);
      int target, cyc;
      target = tiles_done + 1;
      cyc = 0;
      while (tiles_done < target && cyc < 3000) begin step(); cyc++; end
      chk(name, tiles_done, target);
   endtask

   initial begin
      int tc0, fv0, g;
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; ready_for_feed = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_tile_clear", tile_clear, 0);
      chk("rst_feed_valid", feed_valid, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_buses", {row_data_bus, col_data_bus, out_data}, 0);
      step();
      rst_n = 1'b1;
      step();

      // stray completion pulse while idle must be ignored
      stray_req = 1'b1; step(); stray_req = 1'b0; step(); step();

      // identity tile -> 1..16
      load_tile(0);
      wait_tile("t1_done");
      for (int i = 0; i < 16; i++) chk("t1_word", obs[i], i + 1);

      // ones x twos -> all 8, one clear pulse, four feed beats
      tc0 = tc_total; fv0 = fv_total;
      load_tile(1);
      wait_tile("t2_done");
      for (int i = 0; i < 16; i++) chk("t2_word", obs[i], 8);
      chk("t2_clear_cnt", tc_total - tc0, 1);
      chk("t2_feed_cnt", fv_total - fv0, 4);

      // array not ready for 20 cycles after load
      ready_for_feed = 1'b0;
      tc0 = tc_total;
      load_tile(2);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t3_hold_in_ready", in_ready, 0);
         step();
      end
      chk("t3_no_clear", tc_total - tc0, 0);
      ready_for_feed = 1'b1;
      wait_tile("t3_done");

      // random consumer stalls
      rand_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         load_tile(2);
         wait_tile("t4_done");
      end
      rand_ready = 1'b0;

      // watchdog: no completion
      done_en = 1'b0;
      load_tile(2);
      g = 0;
      while (err_timeout !== 1'b1 && g < 600) begin @(negedge clk); g++; end
      chk("t5_err_set", err_timeout, 1);
      @(negedge clk);
      chk("t5_in_ready", in_ready, 1);
      step();
      done_en = 1'b1;
      load_tile(2);
      wait_tile("t5_next_done");
      chk("t5_err_sticky", err_timeout, 1);

      // reset in the middle of the feed
      load_tile(2);
      g = 0;
      @(negedge clk);
      while (feed_valid !== 1'b1 && g < 200) begin @(negedge clk); g++; end
      chk("t6_feed_seen", feed_valid, 1);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_feed_drop", feed_valid, 0);
      chk("t6_clear_drop", tile_clear, 0);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_err_clr", err_timeout, 0);
      @(posedge clk);
      step();
      rst_n = 1'b1;
      step();
      load_tile(2);
      wait_tile("t6_done");

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/systolic_tile_feeder.md
Name: systolic_tile_feeder

Overview:
Initiator-side sequencer that drives one systolic_array_4x4 instance through complete tiles.
- Accepts one tile of operands (A: 4 rows x VECTOR_LENGTH, B: VECTOR_LENGTH x 4 cols) over a valid/ready load stream and buffers it.
- Issues tile_clear, streams VECTOR_LENGTH back-to-back feed beats, and waits for tile_done.
- Captures tile_result_flat and drains the 16 accumulators row-major over a valid/ready output stream.
- Sits between the DMA/operand fetch logic and the array.

Parameters:
INPUT_WIDTH, 8, operand width; must match the array.
ACC_WIDTH, 16, accumulator width; must match the array.
VECTOR_LENGTH, 4, beats per tile (K dimension); must be >= 1.
TIMEOUT_CYCLES, 256, maximum WAIT cycles before err_timeout.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  load beat valid
in_ready  out  1  load beat accepted when in_valid & in_ready
in_a  in  INPUT_WIDTH*4  beat k: A[r][k] in slice r
in_b  in  INPUT_WIDTH*4  beat k: B[k][c] in slice c
ready_for_feed  in  1  from the array; high = array idle
tile_clear  out  1  one-cycle tile start pulse to the array
feed_valid  out  1  feed beat strobe to the array
row_data_bus  out  INPUT_WIDTH*4  A column k to the array
col_data_bus  out  INPUT_WIDTH*4  B row k to the array
tile_done  in  1  one-cycle completion pulse from the array
tile_result_flat  in  ACC_WIDTH*16  result, index r*4+c
out_valid  out  1  result word valid
out_ready  in  1  result consumer ready
out_data  out  ACC_WIDTH  result word
out_last  out  1  high with word index 15
busy  out  1  high in every state except LOAD
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async assert, sync deassert): state=LOAD. tile_clear, feed_valid, out_valid, out_last, err_timeout, and busy are 0. Buses and out_data are 0. All counters are 0. in_ready=1.
- All outputs are registered except in_ready. in_ready is a decode of state==LOAD.
- LOAD:
  - Each accepted beat is written to buffer[beat_cnt]; beat_cnt increments.
  - On acceptance of beat VECTOR_LENGTH-1, go to ARM. No further beats are accepted until the state returns to LOAD.
- ARM:
  - Wait for ready_for_feed=1.
  - In the cycle it is seen, register tile_clear=1 (a one-cycle pulse) and go to FEED. The array sees tile_clear the following cycle.
  - If ready_for_feed is low, hold indefinitely. No timeout applies in ARM.
- FEED:
  - Starts the cycle after tile_clear. feed_valid=1 for exactly VECTOR_LENGTH consecutive cycles.
  - row_data_bus/col_data_bus carry buffer beat 0..VECTOR_LENGTH-1 in order.
  - After the last beat, feed_valid=0, buses return to 0, and the state goes to WAIT.
  - Feed is not gated by ready_for_feed; the array's own skew registers handle alignment.
- WAIT:
  - The watchdog counts from 0.
  - On tile_done=1, latch tile_result_flat into a 16-entry result register, then go to DRAIN with idx=0.
  - If TIMEOUT_CYCLES elapse without tile_done, set err_timeout=1 (sticky until reset), discard the tile, and return to LOAD.
  - A tile_done arriving in any other state is ignored.
- DRAIN:
  - out_valid=1, out_data=result[idx], out_last=(idx==15).
  - On out_valid&out_ready, idx increments. After the transfer with idx 15, out_valid=0 and the state goes to LOAD.
  - out_data is held stable while out_valid&~out_ready (AXI-style: no retraction, no change).
- Throughput: a tile takes VECTOR_LENGTH load + 1 arm + VECTOR_LENGTH feed + array latency + 16 drain cycles minimum. There is no overlap between tiles (single buffer).
- Width rules:
  - beat_cnt is clog2(VECTOR_LENGTH+1) bits.
  - idx is 4 bits.
  - The watchdog is clog2(TIMEOUT_CYCLES+1) bits and saturates.
  - Results pass through unmodified; no sign or width conversion.
- Reset mid-operation from any state returns to LOAD with the buffer contents discarded. The tile_clear or feed_valid pulse in flight is dropped immediately (asynchronous).

Decomposition:
- Shared package systolic_pkg holds:
  - the feeder state enum (LOAD, ARM, FEED, WAIT, DRAIN);
  - localparams ARRAY_ROWS=4, ARRAY_COLS=4, RESULTS_PER_TILE=16.
- One sub-module, tile_operand_buffer: VECTOR_LENGTH-deep register file with a write port (load) and a read port (feed index). Both A and B halves are written in the same beat.
- The FSM, watchdog, and result drain stay in the top level.

Test Plan:
- A = identity (A[r][k]=1 iff r==k), B[k][c]=k*4+c+1, out_ready=1 → out_data sequence 1..16; out_last only on the 16th word; busy falls the cycle after.
- All A=1, all B=2, VECTOR_LENGTH=4 → 16 words all equal 8; tile_clear high exactly 1 cycle; feed_valid high exactly 4 consecutive cycles starting the cycle after tile_clear.
- ready_for_feed held low 20 cycles after load completes → tile_clear not asserted until the cycle after ready_for_feed rises; in_ready=0 throughout.
- Random out_ready stalls (50%) during DRAIN → out_data stable while stalled; exactly 16 transfers in order; no duplicates or drops.
- Array model never pulses tile_done, TIMEOUT_CYCLES=256 → err_timeout=1 at WAIT cycle 256 and stays high; state returns to LOAD with in_ready=1.
- rst_n pulsed low mid-FEED (beat 2) → feed_valid=0 and tile_clear=0 immediately; after release in_ready=1; a following full tile produces correct results.
